// File: rtl/video_pkg.sv
// Shared timing defaults, size helpers and colour-bar decode for the video output pipe.
package video_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Raw per-pixel timing flags carried alongside the coordinate
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } timing_t;

  // Total counts per line or per frame
  function automatic int unsigned span_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  // Counter width able to hold 0..total-1
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

  // Bar 0..7 across the visible line; bit2=red, bit1=green, bit0=blue
  function automatic logic [2:0] bar_index(input int unsigned xv, input int unsigned h_active);
    return 3'((xv * 8) / h_active);
  endfunction

endpackage

// File: rtl/video_out_pipe_delay_line.sv
// Fixed-depth shift register with synchronous clear; depth 0 is a plain wire.
module delay_line
  import video_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];

    // Shift one stage per pixel clock, clear every stage on reset
    always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
        for (int i = 0; i < int'(DEPTH); i++) sr[i] <= '0;
      end else begin
        sr[0] <= din;
        for (int i = 1; i < int'(DEPTH); i++) sr[i] <= sr[i-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/video_out_pipe.sv
// Display timing generator with sync/blank re-alignment to a latent colour source.
module video_out_pipe
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter int unsigned H_POL       = 0,
  parameter int unsigned V_POL       = 0,
  parameter int unsigned PIX_LATENCY = 2,
  parameter int unsigned COLOR_W     = 4,
  localparam int unsigned H_TOTAL    = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int unsigned V_TOTAL    = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int unsigned XW         = cnt_width(H_TOTAL),
  localparam int unsigned YW         = cnt_width(V_TOTAL)
) (
  input  logic               clk_pix,
  input  logic               rst_pix,
  input  logic               pattern_en,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               frame_start,
  output logic               line_start,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               vga_de
);

  localparam int unsigned DW     = XW + $bits(timing_t);
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = V_ACTIVE + V_FP + V_SYNC;
  localparam logic        HS_ON  = 1'(H_POL);
  localparam logic        VS_ON  = 1'(V_POL);

  timing_t           tim0;
  timing_t           tim_d;
  logic [XW-1:0]     x_d;
  logic [DW-1:0]     dl_in;
  logic [DW-1:0]     dl_out;
  logic [2:0]        bar;
  logic [COLOR_W-1:0] src_r;
  logic [COLOR_W-1:0] src_g;
  logic [COLOR_W-1:0] src_b;

  // Raster counters: x every clock, y on the x wrap
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      x <= '0;
      y <= '0;
    end else if (x == XW'(H_TOTAL - 1)) begin
      x <= '0;
      if (y == YW'(V_TOTAL - 1)) y <= '0;
      else                       y <= y + YW'(1);
    end else begin
      x <= x + XW'(1);
    end
  end

  assign frame_start = (x == '0) && (y == '0);
  assign line_start  = (x == '0);

  // Stage-0 timing decode from the counters
  always_comb begin
    tim0        = '0;
    tim0.active = (32'(x) < H_ACTIVE) && (32'(y) < V_ACTIVE);
    tim0.hs     = (32'(x) >= HS_BEG) && (32'(x) < HS_END);
    tim0.vs     = (32'(y) >= VS_BEG) && (32'(y) < VS_END);
  end

  assign dl_in = {x, tim0};

  delay_line #(
    .WIDTH(DW),
    .DEPTH(PIX_LATENCY)
  ) u_delay (
    .clk_pix(clk_pix),
    .rst_pix(rst_pix),
    .din    (dl_in),
    .dout   (dl_out)
  );

  assign {x_d, tim_d} = dl_out;

  // Colour source: external pixel or colour bar for the delayed x
  always_comb begin
    bar   = bar_index(32'(x_d), H_ACTIVE);
    src_r = r_in;
    src_g = g_in;
    src_b = b_in;
    if (pattern_en) begin
      src_r = {COLOR_W{bar[2]}};
      src_g = {COLOR_W{bar[1]}};
      src_b = {COLOR_W{bar[0]}};
    end
  end

  // Output register: syncs, data-enable and blanked colour
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      vga_de    <= 1'b0;
      vga_hsync <= ~HS_ON;
      vga_vsync <= ~VS_ON;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
    end else begin
      vga_de    <= tim_d.active;
      vga_hsync <= tim_d.hs ? HS_ON : ~HS_ON;
      vga_vsync <= tim_d.vs ? VS_ON : ~VS_ON;
      vga_r     <= tim_d.active ? src_r : '0;
      vga_g     <= tim_d.active ? src_g : '0;
      vga_b     <= tim_d.active ? src_b : '0;
    end
  end

endmodule

// File: tb/tb_video_out_pipe.sv
// Bench for video_out_pipe: several parameterisations run side by side on one clock.
module tb_video_out_pipe;

  logic clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  logic rst_a, rst_b, pe0;
  logic [3:0] r3;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int cyc0  = 0;
  bit mon   = 0;

  // default timing, latency 2, own reset
  logic [9:0] x0, y0;
  logic fs0, ls0, hs0, vs0, de0;
  logic [3:0] r0, g0, b0;
  video_out_pipe d0 (
    .clk_pix(clk_pix), .rst_pix(rst_b), .pattern_en(pe0), .x(x0), .y(y0),
    .frame_start(fs0), .line_start(ls0), .r_in(4'h3), .g_in(4'h9), .b_in(4'h6),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hsync(hs0), .vga_vsync(vs0), .vga_de(de0));

  // latency 3 fed by the bench model
  logic [9:0] x3, y3;
  logic fs3, ls3, hs3, vs3, de3;
  logic [3:0] r3o, g3o, b3o;
  video_out_pipe #(.PIX_LATENCY(3)) d3 (
    .clk_pix(clk_pix), .rst_pix(rst_a), .pattern_en(1'b0), .x(x3), .y(y3),
    .frame_start(fs3), .line_start(ls3), .r_in(r3), .g_in(4'h5), .b_in(4'hA),
    .vga_r(r3o), .vga_g(g3o), .vga_b(b3o), .vga_hsync(hs3), .vga_vsync(vs3), .vga_de(de3));

  // latency 0
  logic [9:0] xz, yz;
  logic fsz, lsz, hsz, vsz, dez;
  logic [3:0] rz, gz, bz;
  video_out_pipe #(.PIX_LATENCY(0)) dz (
    .clk_pix(clk_pix), .rst_pix(rst_a), .pattern_en(1'b0), .x(xz), .y(yz),
    .frame_start(fsz), .line_start(lsz), .r_in(4'h1), .g_in(4'h2), .b_in(4'h3),
    .vga_r(rz), .vga_g(gz), .vga_b(bz), .vga_hsync(hsz), .vga_vsync(vsz), .vga_de(dez));

  // latency 15
  logic [9:0] xf, yf;
  logic fsf, lsf, hsf, vsf, def;
  logic [3:0] rf, gf, bf;
  video_out_pipe #(.PIX_LATENCY(15)) df (
    .clk_pix(clk_pix), .rst_pix(rst_a), .pattern_en(1'b0), .x(xf), .y(yf),
    .frame_start(fsf), .line_start(lsf), .r_in(4'h1), .g_in(4'h2), .b_in(4'h3),
    .vga_r(rf), .vga_g(gf), .vga_b(bf), .vga_hsync(hsf), .vga_vsync(vsf), .vga_de(def));

  // tiny timing, active-high syncs: 14 x 7
  logic [3:0] xp;
  logic [2:0] yp;
  logic fsp, lsp, hsp, vsp, dep;
  logic [3:0] rp, gp, bp;
  video_out_pipe #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .H_POL(1), .V_POL(1)) dp (
    .clk_pix(clk_pix), .rst_pix(rst_a), .pattern_en(1'b0), .x(xp), .y(yp),
    .frame_start(fsp), .line_start(lsp), .r_in(4'h1), .g_in(4'h2), .b_in(4'h3),
    .vga_r(rp), .vga_g(gp), .vga_b(bp), .vga_hsync(hsp), .vga_vsync(vsp), .vga_de(dep));

  // latency-3 source model and its checker state
  logic [9:0] hist [8];
  int l3_n = 0, l3_bad = 0;

  // window counters
  int fs0_n = 0, ls0_n = 0, hs0_n = 0, vs0_n = 0, de0_n = 0, hs0_first = -1, de0_first = -1;
  int dz_first = -1, df_first = -1;
  int fsp_n = 0, lsp_n = 0, hsp_n = 0, vsp_n = 0, dep_n = 0, hsp_first = -1, vsp_first = -1;

  typedef struct {
    bit         pe;
    int         px;
    logic [14:0] exp;  // {de, hsync, r, g, b}
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic sample();
    int c;
    c = cyc - cyc0;
    if (!mon) return;
    if (c < 1600) begin
      fs0_n += int'(fs0);
      ls0_n += int'(ls0);
      if (!hs0) begin hs0_n++; if (hs0_first < 0) hs0_first = c; end
      if (!vs0) vs0_n++;
      if (de0) begin de0_n++; if (de0_first < 0) de0_first = c; end
    end
    if (c < 100) begin
      if (dez && dz_first < 0) dz_first = c;
      if (def && df_first < 0) df_first = c;
    end
    if (c >= 3 && c < 199) begin
      fsp_n += int'(fsp);
      lsp_n += int'(lsp);
      dep_n += int'(dep);
      if (hsp) begin hsp_n++; if (hsp_first < 0) hsp_first = c; end
      if (vsp) begin vsp_n++; if (vsp_first < 0) vsp_first = c; end
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    #1;
    cyc++;
    hist[cyc % 8] = x3;
    r3 = hist[(cyc + 5) % 8][3:0];
    if (de3) begin
      l3_n++;
      if (r3o !== hist[(cyc + 4) % 8][3:0] || g3o !== 4'h5 || b3o !== 4'hA) l3_bad++;
    end else if ({r3o, g3o, b3o} !== 12'h0) begin
      l3_bad++;
    end
    sample();
  endtask

  initial begin
    vec_t vt [13];
    int guard;

    vt[0]  = '{1'b1, 0,   15'b11_0000_0000_0000};
    vt[1]  = '{1'b1, 79,  15'b11_0000_0000_0000};
    vt[2]  = '{1'b1, 80,  15'b11_0000_0000_1111};
    vt[3]  = '{1'b1, 159, 15'b11_0000_0000_1111};
    vt[4]  = '{1'b1, 160, 15'b11_0000_1111_0000};
    vt[5]  = '{1'b1, 320, 15'b11_1111_0000_0000};
    vt[6]  = '{1'b1, 559, 15'b11_1111_1111_0000};
    vt[7]  = '{1'b1, 560, 15'b11_1111_1111_1111};
    vt[8]  = '{1'b1, 639, 15'b11_1111_1111_1111};
    vt[9]  = '{1'b1, 640, 15'b01_0000_0000_0000};
    vt[10] = '{1'b1, 700, 15'b00_0000_0000_0000};
    vt[11] = '{1'b0, 100, 15'b11_0011_1001_0110};
    vt[12] = '{1'b0, 639, 15'b11_0011_1001_0110};

    for (int i = 0; i < 8; i++) hist[i] = '0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    pe0   = 1'b1;
    r3    = '0;
    repeat (4) step();

    // reset state
    check("rst_x", 32'(x0), 0);
    check("rst_y", 32'(y0), 0);
    check("rst_frame_start", 32'(fs0), 1);
    check("rst_de", 32'(de0), 0);
    check("rst_syncs_low_pol", 32'({hs0, vs0}), 3);
    check("rst_rgb", 32'({r0, g0, b0}), 0);
    check("rst_syncs_high_pol", 32'({hsp, vsp}), 0);

    // release and watch two default lines / two tiny frames
    rst_a = 1'b0;
    rst_b = 1'b0;
    cyc0  = cyc;
    mon   = 1'b1;
    sample();
    repeat (1700) step();
    mon = 1'b0;

    check("line_frame_start_n", 32'(fs0_n), 1);
    check("line_line_start_n", 32'(ls0_n), 2);
    check("line_hsync_low_n", 32'(hs0_n), 192);
    check("line_hsync_first", 32'(hs0_first), 659);
    check("line_vsync_low_n", 32'(vs0_n), 0);
    check("line_de_n", 32'(de0_n), 1280);
    check("line_de_first", 32'(de0_first), 3);
    check("lat0_de_first", 32'(dz_first), 1);
    check("lat15_de_first", 32'(df_first), 16);
    check("pol_frame_start_n", 32'(fsp_n), 2);
    check("pol_line_start_n", 32'(lsp_n), 14);
    check("pol_hsync_high_n", 32'(hsp_n), 28);
    check("pol_vsync_high_n", 32'(vsp_n), 28);
    check("pol_de_n", 32'(dep_n), 64);
    check("pol_hsync_first", 32'(hsp_first), 13);
    check("pol_vsync_first", 32'(vsp_first), 73);

    // colour bars / passthrough vectors: pixel p appears when x has moved on by 3
    for (int i = 0; i < 13; i++) begin
      pe0 = vt[i].pe;
      guard = 0;
      while (32'(x0) != 32'(vt[i].px + 3) && guard < 2000) begin
        step();
        guard++;
      end
      if (guard >= 2000) check($sformatf("vec%0d_timeout", i), 32'(guard), 0);
      else check($sformatf("vec%0d_px%0d", i, vt[i].px), 32'({de0, hs0, r0, g0, b0}), 32'(vt[i].exp));
    end

    // one-cycle reset in the middle of a visible line
    pe0 = 1'b0;
    guard = 0;
    while (x0 != 10'd300 && guard < 1000) begin
      step();
      guard++;
    end
    check("mid_reach_x300", 32'(guard < 1000), 1);
    rst_b = 1'b1;
    step();
    check("mid_xy", 32'({x0, y0}), 0);
    check("mid_de", 32'(de0), 0);
    check("mid_syncs", 32'({hs0, vs0}), 3);
    check("mid_rgb", 32'({r0, g0, b0}), 0);
    rst_b = 1'b0;
    check("mid_fs_release", 32'(fs0), 1);
    step();
    check("mid_fs_next", 32'({fs0, x0}), 32'({1'b0, 10'd1}));
    step();
    step();
    check("mid_de_return", 32'({de0, r0, g0, b0}), 32'({1'b1, 12'h396}));

    // latency-3 colour alignment over the whole run
    check("lat3_rgb_errors", 32'(l3_bad), 0);
    check("lat3_de_seen", 32'(l3_n > 1000), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
